montgomery_mult_param: RTL

MONTGOMERY_MULT_PARAM -- requirements
Module: montgomery_mult_param

---
 rtl/montgomery_mult_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/montgomery_mult_param.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One bit of A is consumed per clock, LSB first, followed by an optional
// conditional subtraction that brings the result below M.
module montgomery_mult_param #(
  parameter int WIDTH     = 1024,
  parameter bit FINAL_SUB = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, SUB, DONE} state_t;

  state_t state, state_d;
  logic   busy_d, done_d, err_d;

  logic [WIDTH-1:0] a_reg, b_reg, m_reg;
  logic [WIDTH:0]   c_reg, c_next;
  logic [CNT_W-1:0] cnt;

  // One iteration: T = C + a_i*B, make T even by adding M, then halve.
  // T is held at WIDTH+2 bits: C < 2^(WIDTH+1) and B, M < 2^WIDTH keep it in range.
  function automatic logic [WIDTH:0] mont_step(input logic [WIDTH:0]   c,
                                               input logic             a_bit,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] t;
    t = {1'b0, c} + (a_bit ? {2'b00, b} : '0);
    if (t[0]) t = t + {2'b00, m};
    return t[WIDTH+1:1];
  endfunction

  // Final reduction from [0, 2M) to [0, M).
  function automatic logic [WIDTH:0] final_reduce(input logic [WIDTH:0]   c,
                                                  input logic [WIDTH-1:0] m);
    return (c >= {1'b0, m}) ? (c - {1'b0, m}) : c;
  endfunction

  // Datapath step for the current bit of A.
  always_comb begin
    c_next = mont_step(c_reg, a_reg[0], b_reg, m_reg);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      err   <= err_d;
    end
  end

  // Next-state selection; an even modulus bypasses the iteration entirely.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = in_m[0] ? COMPUTE : DONE;
      COMPUTE: begin
        if (abort)                 state_d = IDLE;
        else if (cnt == LAST_BIT)  state_d = FINAL_SUB ? SUB : DONE;
      end
      SUB:     state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register with it.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state == IDLE) && start && !in_m[0];
  end

  // Operand capture at start; A shifts right so bit 0 is always the current a_i.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_reg <= in_a;
      b_reg <= in_b;
      m_reg <= in_m;
    end else if (state == COMPUTE) begin
      a_reg <= a_reg >> 1;
    end
  end

  // Accumulator, bit counter and result; result holds until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_reg  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            c_reg <= '0;
            cnt   <= '0;
            if (!in_m[0]) result <= '0;
          end
        end
        COMPUTE: begin
          if (!abort) begin
            c_reg <= c_next;
            cnt   <= cnt + CNT_W'(1);
            if (!FINAL_SUB && cnt == LAST_BIT) result <= c_next;
          end
        end
        SUB: begin
          if (!abort) result <= final_reduce(c_reg, m_reg);
        end
        default: ;
      endcase
    end
  end

endmodule
